// File: rtl/ysyx_22040931_branch_predictor_pkg.sv
// Shared definitions for the branch predictor: ID jump-type codes, PC bus width,
// 2-bit counter init values and the saturating counter step.
package ysyx_22040931_branch_predictor_pkg;

  localparam int ysyx_22040931_PC_BUS = 64;

  localparam logic [1:0] JT_B    = 2'b01;
  localparam logic [1:0] JT_J    = 2'b10;
  localparam logic [1:0] JT_JALR = 2'b11;

  localparam logic [1:0] WEAK_T   = 2'b10;
  localparam logic [1:0] STRONG_T = 2'b11;

  // Saturating 2-bit counter: 11 is the ceiling, 00 the floor.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22040931_branch_predictor_ras.sv
// Circular return-address stack trained at ID resolution (non-speculative).
// Pushing when full overwrites the oldest entry; popping when empty is ignored.
module ysyx_22040931_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH;

  logic [W-1:0]  r_stack [DEPTH];
  logic [PW-1:0] r_ptr;       // next free slot
  logic [PW:0]   r_count;
  logic [PW-1:0] w_top_idx;
  logic          w_do_pop;

  assign w_top_idx = r_ptr - PTR_ONE;
  assign w_do_pop  = pop & (r_count != '0);
  assign top       = r_stack[w_top_idx];
  assign empty     = (r_count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_pop && push) begin
      // pop-then-push collapses to replacing the top in place
      r_stack[w_top_idx] <= push_data;
    end else if (w_do_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_ONE;
    end else if (push) begin
      r_stack[r_ptr] <= push_data;
      r_ptr          <= r_ptr + PTR_ONE;
      if (r_count != CNT_FULL) r_count <= r_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/ysyx_22040931_branch_predictor.sv
// Dynamic branch predictor: direct-mapped flop BTB with 2-bit counters, optional RAS,
// zero-latency lookup for IF, training from ID, saturating accuracy counters.
module ysyx_22040931_branch_predictor
  import ysyx_22040931_branch_predictor_pkg::*;
#(
  parameter int PC_W      = ysyx_22040931_PC_BUS,
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 4,
  parameter bit RAS_EN    = 1'b1,
  parameter int PERF_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispred,
  input  logic              upd_is_call,
  input  logic              upd_is_ret,
  output logic [PERF_W-1:0] perf_total,
  output logic [PERF_W-1:0] perf_correct
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [PC_W-1:0]   PC_FOUR  = 4;
  localparam logic [PERF_W-1:0] PERF_ONE = 1;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_type   [ENTRIES];
  logic               r_is_ret [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [PERF_W-1:0]  r_total, r_correct;

  logic [IDX_W-1:0] w_if_idx, w_upd_idx;
  logic [TAG_W-1:0] w_if_tag, w_upd_tag;
  logic             w_if_hit, w_upd_hit, w_use_ras, w_upd_jump;
  logic [PC_W-1:0]  w_ras_top;
  logic             w_ras_empty;
  logic             w_unused_bits;

  // Low two PC bits never take part in indexing; upper bits beyond the tag are dropped.
  assign w_if_idx  = if_pc[IDX_W+1:2];
  assign w_if_tag  = if_pc[IDX_W+2 +: TAG_W];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[IDX_W+2 +: TAG_W];
  assign w_unused_bits = ^{if_pc, upd_pc, upd_is_call, upd_is_ret};

  assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_jump = (upd_type == JT_J) || (upd_type == JT_JALR);

  assign pred_taken = w_if_hit && ((r_type[w_if_idx] != JT_B) || r_ctr[w_if_idx][1]);
  assign w_use_ras  = w_if_hit && r_is_ret[w_if_idx] && !w_ras_empty;

  always_comb begin
    pred_target = if_pc + PC_FOUR;
    if (w_use_ras)       pred_target = w_ras_top;
    else if (pred_taken) pred_target = r_target[w_if_idx];
  end

  // BTB training; lookups in the same cycle still see the pre-update entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_upd_jump ? STRONG_T : ctr_step(r_ctr[w_upd_idx], upd_taken);
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_type[w_upd_idx]   <= upd_type;
        r_is_ret[w_upd_idx] <= upd_is_ret;
        r_ctr[w_upd_idx]    <= w_upd_jump ? STRONG_T : WEAK_T;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (upd_valid) begin
      if (r_total != PERF_MAX) r_total <= r_total + PERF_ONE;
      if (!upd_mispred && (r_correct != PERF_MAX)) r_correct <= r_correct + PERF_ONE;
    end
  end

  assign perf_total   = r_total;
  assign perf_correct = r_correct;

  generate
    if (RAS_EN) begin : g_ras
      ysyx_22040931_ras #(
        .DEPTH(RAS_DEPTH),
        .W    (PC_W)
      ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (upd_valid & upd_is_call),
        .pop      (upd_valid & upd_is_ret),
        .push_data(upd_pc + PC_FOUR),
        .top      (w_ras_top),
        .empty    (w_ras_empty)
      );
    end else begin : g_no_ras
      assign w_ras_top   = '0;
      assign w_ras_empty = 1'b1;
    end
  endgenerate

endmodule
